pattern_gen: RTL
================

Name: pattern_gen

Overview:
- Synthesizable, parametrised multi-channel periodic waveform generator.
- Each channel replays a programmable table of (level, duration) segments cyclically. Example: 0 for 1, 1 for 2, 0 for 3, 1 for 4, repeat.
- Used as the stimulus/timing source in bench tops and as on-chip test-pattern source; replaces hard-coded delay loops.

Parameters:
- CH_NUM, 4, number of independent channels.
- SEG_DEPTH, 4, segments per channel table (power of 2, >=2).
- DUR_W, 8, width of segment duration field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_we  input  1  write one table entry this cycle.
- cfg_ch  input  $clog2(CH_NUM)  target channel.
- cfg_seg  input  $clog2(SEG_DEPTH)  target segment index.
- cfg_level  input  1  output level for the segment.
- cfg_dur  input  DUR_W  segment length in cycles; 0 treated as 1.
- cfg_last  input  1  segment ends the sequence; wrap to seg 0 after it.
- start  input  CH_NUM  per-channel start/restart pulse.
- stop  input  CH_NUM  per-channel stop pulse.
- wave_out  output  CH_NUM  generated waveform.
- busy  output  CH_NUM  channel in RUN.
- wrap_pulse  output  CH_NUM  1-cycle pulse on the first cycle of seg 0 after a wrap.

Behaviour:
- Reset (async, rst_n=0):
  - wave_out, busy and wrap_pulse = 0.
  - All table entries cleared: level 0, dur 0, last 0.
  - All channels go to IDLE.
- Per-channel FSM: IDLE, RUN.
  - IDLE: wave_out=0, busy=0.
  - start sampled at edge k -> RUN. From cycle k+1: wave_out = level[0], busy=1, duration counter loaded with max(dur[0],1).
  - RUN: counter decrements each cycle. When it reaches 1:
    - If the segment is last, or its index = SEG_DEPTH-1, the next cycle loads seg 0.
    - Otherwise the next cycle loads seg+1.
  - wave_out changes only at segment boundaries. A segment with duration D holds its level for exactly D cycles.
  - Implicit wrap at SEG_DEPTH-1 even if no entry has last set.
- wrap_pulse: high for one cycle coincident with the first cycle of seg 0 after a wrap. Not asserted on the initial start.
- stop in RUN -> IDLE at the next edge; wave_out=0 from the next cycle.
- start in RUN -> restart at seg 0 next cycle; no wrap_pulse.
- start and stop in the same cycle: stop wins.
- stop in IDLE: no effect.
- Config writes:
  - Allowed at any time, including to a running channel.
  - The new entry is used the next time that segment is loaded. The segment currently playing is unaffected.
  - cfg_ch >= CH_NUM: write ignored.
- Channels are fully independent; no cross-channel timing relationship.

Optional Feature:
- Macro: PATTERN_GEN_REPEAT_CNT_EN.
- With the macro defined:
  - Adds ports cfg_rep_we (input 1), cfg_rep (input 8) and done (output CH_NUM).
  - cfg_rep_we writes the repeat count for channel cfg_ch. 0 = infinite.
  - For count N, the channel plays N full passes then returns to IDLE at the point where the wrap would occur.
  - done pulses for 1 cycle on the first IDLE cycle. No wrap_pulse for the final pass.
  - Reset clears counts to 0 (infinite).
- Without the macro: these ports are absent and every channel repeats indefinitely.

Decomposition:
- Package pattern_gen_pkg:
  - state enum (ST_IDLE, ST_RUN).
  - segment struct {level, dur, last}.
  - localparams for index widths.
- Sub-module pattern_gen_ch: one channel's FSM, duration counter, segment index and optional repeat counter. Reads its table slice combinationally.
- Top pattern_gen: holds the config table and write decode, and instantiates CH_NUM pattern_gen_ch via a generate loop.

Test Plan:
- Program ch0 as (0,1)(1,2)(0,3)(1,4,last); pulse start -> wave_out[0] runs the 10-cycle period 0,1,1,0,0,0,1,1,1,1. wrap_pulse[0] fires every 10 cycles starting 10 cycles after the first busy cycle.
- Program ch1 as (1,2)(0,2) with no last flag, SEG_DEPTH=4, seg2/seg3 left at reset -> after seg1 plays seg2 and seg3 as level 0 for 1 cycle each; 6-cycle period 1,1,0,0,0,0.
- Run ch0; assert start and stop together -> IDLE next cycle, wave_out[0]=0, busy[0]=0.
- Run ch2; rewrite seg1 dur from 3 to 5 while seg0 plays -> seg1 lasts 5 cycles on this pass. Rewrite seg1 while seg1 plays -> current length unchanged.
- Assert rst_n low mid-segment (asynchronously, between clock edges) -> all outputs 0 immediately. After release, start gives seg0 = level 0, dur 1 (cleared table).
- With PATTERN_GEN_REPEAT_CNT_EN, cfg_rep=2 on a 10-cycle pattern -> 20 busy cycles, one wrap_pulse, then done pulse and IDLE.

Source files
------------

// File: rtl/pattern_gen_pkg.sv
// Shared types for the pattern_gen waveform generator: channel state, table entry
// layout and index-width helpers.
package pattern_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Stored duration width; the top's DUR_W port width should match it.
  localparam int PG_DUR_W = 8;
  localparam int REP_W    = 8;

  typedef struct packed {
    logic                level;
    logic [PG_DUR_W-1:0] dur;
    logic                last;
  } seg_t;

  // Index width that stays >= 1 even for a single entry.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A programmed duration of 0 plays for one cycle.
  function automatic logic [PG_DUR_W-1:0] dur_len(input logic [PG_DUR_W-1:0] d);
    return (d == '0) ? PG_DUR_W'(1) : d;
  endfunction

endpackage

// File: rtl/pattern_gen_ch.sv
// One pattern_gen channel: IDLE/RUN FSM, duration counter and segment index.
// With PATTERN_GEN_REPEAT_CNT_EN it also counts passes and stops after rep of them.
module pattern_gen_ch
  import pattern_gen_pkg::*;
#(
  parameter int SEG_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  seg_t [SEG_DEPTH-1:0]   tbl,
`ifdef PATTERN_GEN_REPEAT_CNT_EN
  input  logic [REP_W-1:0]       rep,
  output logic                   done,
`endif
  output logic                   wave,
  output logic                   busy,
  output logic                   wrap_pulse
);

  localparam int SEG_W = idx_w(SEG_DEPTH);
  localparam logic [SEG_W-1:0] SEG_MAX = SEG_W'(SEG_DEPTH - 1);

  state_e              state;
  logic [SEG_W-1:0]    seg;
  logic [PG_DUR_W-1:0] cnt;
  logic                cur_last;
  logic                wrap_now;
  logic                final_pass;
  logic [SEG_W-1:0]    nxt_seg;
  seg_t                nxt;

  // The last flag is latched at load so rewriting the playing entry has no effect.
  always_comb begin
    wrap_now = cur_last || (seg == SEG_MAX);
    nxt_seg  = wrap_now ? '0 : seg + SEG_W'(1);
    nxt      = tbl[nxt_seg];
  end

`ifdef PATTERN_GEN_REPEAT_CNT_EN
  logic [REP_W-1:0] pass;
  assign final_pass = (rep != '0) && (pass == rep - REP_W'(1));
`else
  assign final_pass = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      seg        <= '0;
      cnt        <= '0;
      cur_last   <= 1'b0;
      wave       <= 1'b0;
      busy       <= 1'b0;
      wrap_pulse <= 1'b0;
`ifdef PATTERN_GEN_REPEAT_CNT_EN
      pass       <= '0;
      done       <= 1'b0;
`endif
    end else begin
      wrap_pulse <= 1'b0;
`ifdef PATTERN_GEN_REPEAT_CNT_EN
      done       <= 1'b0;
`endif
      if (stop) begin
        state <= ST_IDLE;
        wave  <= 1'b0;
        busy  <= 1'b0;
      end else if (start) begin
        state    <= ST_RUN;
        busy     <= 1'b1;
        seg      <= '0;
        cnt      <= dur_len(tbl[0].dur);
        wave     <= tbl[0].level;
        cur_last <= tbl[0].last;
`ifdef PATTERN_GEN_REPEAT_CNT_EN
        pass     <= '0;
`endif
      end else if (state == ST_RUN) begin
        if (cnt > PG_DUR_W'(1)) begin
          cnt <= cnt - PG_DUR_W'(1);
        end else if (wrap_now && final_pass) begin
          state <= ST_IDLE;
          wave  <= 1'b0;
          busy  <= 1'b0;
`ifdef PATTERN_GEN_REPEAT_CNT_EN
          done  <= 1'b1;
`endif
        end else begin
          seg        <= nxt_seg;
          cnt        <= dur_len(nxt.dur);
          wave       <= nxt.level;
          cur_last   <= nxt.last;
          wrap_pulse <= wrap_now;
`ifdef PATTERN_GEN_REPEAT_CNT_EN
          if (wrap_now) pass <= pass + REP_W'(1);
`endif
        end
      end
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// Multi-channel periodic waveform generator: config table plus CH_NUM channel engines.
// Optional per-channel repeat count under PATTERN_GEN_REPEAT_CNT_EN.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int CH_NUM    = 4,
  parameter int SEG_DEPTH = 4,
  parameter int DUR_W     = PG_DUR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [idx_w(CH_NUM)-1:0]      cfg_ch,
  input  logic [idx_w(SEG_DEPTH)-1:0]   cfg_seg,
  input  logic                          cfg_level,
  input  logic [DUR_W-1:0]              cfg_dur,
  input  logic                          cfg_last,
  input  logic [CH_NUM-1:0]             start,
  input  logic [CH_NUM-1:0]             stop,
  output logic [CH_NUM-1:0]             wave_out,
  output logic [CH_NUM-1:0]             busy,
  output logic [CH_NUM-1:0]             wrap_pulse
`ifdef PATTERN_GEN_REPEAT_CNT_EN
  ,
  input  logic                          cfg_rep_we,
  input  logic [REP_W-1:0]              cfg_rep,
  output logic [CH_NUM-1:0]             done
`endif
);

  localparam int CH_W = idx_w(CH_NUM);

  seg_t [CH_NUM-1:0][SEG_DEPTH-1:0] tbl;
  logic                             cfg_ok;

  assign cfg_ok = ({1'b0, cfg_ch} < (CH_W + 1)'(CH_NUM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl <= '0;
    end else if (cfg_we && cfg_ok) begin
      tbl[cfg_ch][cfg_seg] <= '{level: cfg_level, dur: PG_DUR_W'(cfg_dur), last: cfg_last};
    end
  end

`ifdef PATTERN_GEN_REPEAT_CNT_EN
  logic [CH_NUM-1:0][REP_W-1:0] rep_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (cfg_rep_we && cfg_ok) begin
      rep_cnt[cfg_ch] <= cfg_rep;
    end
  end
`endif

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    pattern_gen_ch #(
      .SEG_DEPTH (SEG_DEPTH)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start[i]),
      .stop       (stop[i]),
      .tbl        (tbl[i]),
`ifdef PATTERN_GEN_REPEAT_CNT_EN
      .rep        (rep_cnt[i]),
      .done       (done[i]),
`endif
      .wave       (wave_out[i]),
      .busy       (busy[i]),
      .wrap_pulse (wrap_pulse[i])
    );
  end

endmodule
